// File: rtl/auto_music_pkg.sv
// Shared types and note/frequency tables for the autoplay engine.
// Note codes: 0 rest, 1..7 low octave (C4..B4), 8..14 mid (C5..B5), 15..21 high (C6..B6), 22..31 rest.
package auto_music_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSED,
        ST_DONE
    } player_state_e;

    localparam logic [4:0] NOTE_REST = 5'd0;
    localparam logic [4:0] NOTE_L1 = 5'd1;
    localparam logic [4:0] NOTE_L2 = 5'd2;
    localparam logic [4:0] NOTE_L3 = 5'd3;
    localparam logic [4:0] NOTE_L4 = 5'd4;
    localparam logic [4:0] NOTE_L5 = 5'd5;
    localparam logic [4:0] NOTE_L6 = 5'd6;
    localparam logic [4:0] NOTE_L7 = 5'd7;
    localparam logic [4:0] NOTE_M1 = 5'd8;
    localparam logic [4:0] NOTE_M2 = 5'd9;
    localparam logic [4:0] NOTE_M3 = 5'd10;
    localparam logic [4:0] NOTE_M4 = 5'd11;
    localparam logic [4:0] NOTE_M5 = 5'd12;
    localparam logic [4:0] NOTE_M6 = 5'd13;
    localparam logic [4:0] NOTE_M7 = 5'd14;
    localparam logic [4:0] NOTE_H1 = 5'd15;
    localparam logic [4:0] NOTE_H2 = 5'd16;
    localparam logic [4:0] NOTE_H3 = 5'd17;
    localparam logic [4:0] NOTE_H4 = 5'd18;
    localparam logic [4:0] NOTE_H5 = 5'd19;
    localparam logic [4:0] NOTE_H6 = 5'd20;
    localparam logic [4:0] NOTE_H7 = 5'd21;

    localparam int unsigned FREQ_HZ [32] = '{
        0,
        262, 294, 330, 349, 392, 440, 494,
        523, 587, 659, 698, 784, 880, 988,
        1047, 1175, 1319, 1397, 1568, 1760, 1976,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0
    };

    // Half-period in clk cycles; 0 marks a rest code.
    function automatic int unsigned half_period(input int unsigned clk_hz, input int unsigned code);
        if (code == 0 || code > 21) begin
            return 0;
        end
        return clk_hz / (2 * FREQ_HZ[code[4:0]]);
    endfunction

endpackage

// File: rtl/music_rom.sv
// Combinational song store: (song, beat) -> note code. Beats or songs
// beyond the stored patterns read as rest.
module music_rom
    import auto_music_pkg::*;
#(
    parameter int unsigned SONG_LEN  = 128,
    parameter int unsigned NUM_SONGS = 4,
    parameter int unsigned NOTE_W    = 5,
    parameter int unsigned SONG_W    = 2,
    parameter int unsigned BIDX_W    = 7
)(
    input  logic [SONG_W-1:0] song_i,
    input  logic [BIDX_W-1:0] beat_i,
    output logic [NOTE_W-1:0] note_o
);

    localparam int unsigned PAT_LEN = 16;

    localparam logic [4:0] SONGS [4][PAT_LEN] = '{
        '{NOTE_M1, NOTE_M1, NOTE_M5, NOTE_M5, NOTE_M6, NOTE_M6, NOTE_M5, NOTE_REST,
          NOTE_M4, NOTE_M4, NOTE_M3, NOTE_M3, NOTE_M2, NOTE_M2, NOTE_M1, NOTE_REST},
        '{NOTE_L1, NOTE_L3, NOTE_L5, NOTE_M1, NOTE_REST, NOTE_H1, NOTE_H7, 5'd25,
          NOTE_M7, NOTE_M6, NOTE_M5, NOTE_M4, NOTE_M3, NOTE_M2, NOTE_M1, NOTE_REST},
        '{NOTE_M3, NOTE_M2, NOTE_M1, NOTE_M2, NOTE_M3, NOTE_M3, NOTE_M3, NOTE_REST,
          NOTE_M2, NOTE_M2, NOTE_M2, NOTE_REST, NOTE_M3, NOTE_M5, NOTE_M5, NOTE_REST},
        '{NOTE_H1, NOTE_M7, NOTE_M6, NOTE_M5, NOTE_M4, NOTE_M3, NOTE_M2, NOTE_M1,
          NOTE_L7, NOTE_L6, NOTE_L5, NOTE_L4, NOTE_L3, NOTE_L2, NOTE_L1, NOTE_REST}
    };

    logic [1:0] song_ix;
    logic [3:0] beat_ix;

    always_comb begin
        song_ix = 2'(song_i);
        beat_ix = 4'(beat_i);
        note_o  = '0;
        if (32'(song_i) < NUM_SONGS && 32'(song_i) < 4 &&
            32'(beat_i) < PAT_LEN && 32'(beat_i) < SONG_LEN) begin
            note_o = NOTE_W'(SONGS[song_ix][beat_ix]);
        end
    end

endmodule

// File: rtl/auto_music_player.sv
// Autoplay engine: beat sequencer over music_rom plus inline square-wave tone generator.
// Optional AUTO_MUSIC_ARTIC_EN silences the tail of a beat that is followed by the same note.
module auto_music_player
    import auto_music_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned BEAT_CYCLES = 6250000,
    parameter int unsigned SONG_LEN    = 128,
    parameter int unsigned NUM_SONGS   = 4,
    parameter int unsigned NOTE_W      = 5,
    localparam int unsigned SONG_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    localparam int unsigned BIDX_W     = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [SONG_W-1:0] song_sel,
    output logic              buzzer,
    output logic              playing,
    output logic              paused,
    output logic              done,
    output logic [BIDX_W-1:0] beat_idx,
    output logic [NOTE_W-1:0] note_cur
);

    localparam int unsigned BCNT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int unsigned TONE_W = $clog2(half_period(CLK_HZ, 1) + 1);

    player_state_e     state_q, state_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [BIDX_W-1:0] beat_idx_q, beat_idx_d;
    logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              buzz_q, buzz_d;
    logic              done_q, done_d;

    logic [NOTE_W-1:0] rom_note;
    logic [TONE_W-1:0] half_tab [32];
    logic [TONE_W-1:0] half;
    logic              beat_end, song_end, artic_gap;

    music_rom #(
        .SONG_LEN (SONG_LEN),
        .NUM_SONGS(NUM_SONGS),
        .NOTE_W   (NOTE_W),
        .SONG_W   (SONG_W),
        .BIDX_W   (BIDX_W)
    ) u_rom (
        .song_i(song_q),
        .beat_i(beat_idx_q),
        .note_o(rom_note)
    );

    for (genvar gi = 0; gi < 32; gi++) begin : g_half
        assign half_tab[gi] = TONE_W'(half_period(CLK_HZ, gi));
    end

`ifdef AUTO_MUSIC_ARTIC_EN
    logic [BIDX_W-1:0] next_idx;
    logic [NOTE_W-1:0] next_note;

    assign next_idx = song_end ? '0 : beat_idx_q + 1'b1;

    music_rom #(
        .SONG_LEN (SONG_LEN),
        .NUM_SONGS(NUM_SONGS),
        .NOTE_W   (NOTE_W),
        .SONG_W   (SONG_W),
        .BIDX_W   (BIDX_W)
    ) u_rom_next (
        .song_i(song_q),
        .beat_i(next_idx),
        .note_o(next_note)
    );

    // With BEAT_CYCLES < 8 the threshold equals BEAT_CYCLES, so the gap never opens.
    assign artic_gap = (32'(beat_cnt_q) >= BEAT_CYCLES - BEAT_CYCLES / 8) && (next_note == note_q);
`else
    assign artic_gap = 1'b0;
`endif

    assign beat_end = (beat_cnt_q == BCNT_W'(BEAT_CYCLES - 1));
    assign song_end = (beat_idx_q == BIDX_W'(SONG_LEN - 1));

    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        beat_idx_d = beat_idx_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = 1'b0;
        if (stop) begin
            state_d    = ST_IDLE;
            beat_idx_d = '0;
            beat_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d    = ST_PLAY;
                        song_d     = song_sel;
                        beat_idx_d = '0;
                        beat_cnt_d = '0;
                    end
                end
                ST_PLAY: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (beat_end) begin
                        beat_cnt_d = '0;
                        if (song_end) begin
                            done_d     = 1'b1;
                            beat_idx_d = '0;
                            if (!loop_en) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            beat_idx_d = beat_idx_q + 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_PLAY;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Tone phase is held across a pause; the visible buzzer is gated by PLAY.
    always_comb begin
        note_d     = (state_q == ST_PLAY || state_q == ST_PAUSED) ? rom_note : '0;
        half       = (note_q > NOTE_W'(NOTE_H7)) ? '0 : half_tab[note_q[4:0]];
        tone_cnt_d = tone_cnt_q;
        buzz_d     = buzz_q;
        if (!(state_d inside {ST_PLAY, ST_PAUSED}) || half == '0 || note_d != note_q || artic_gap) begin
            tone_cnt_d = '0;
            buzz_d     = 1'b0;
        end else if (state_q == ST_PLAY && state_d == ST_PLAY) begin
            if (tone_cnt_q == half - 1'b1) begin
                tone_cnt_d = '0;
                buzz_d     = ~buzz_q;
            end else begin
                tone_cnt_d = tone_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            song_q     <= '0;
            beat_idx_q <= '0;
            beat_cnt_q <= '0;
            note_q     <= '0;
            tone_cnt_q <= '0;
            buzz_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            beat_idx_q <= beat_idx_d;
            beat_cnt_q <= beat_cnt_d;
            note_q     <= note_d;
            tone_cnt_q <= tone_cnt_d;
            buzz_q     <= buzz_d;
            done_q     <= done_d;
        end
    end

    assign playing  = (state_q == ST_PLAY);
    assign paused   = (state_q == ST_PAUSED);
    assign buzzer   = buzz_q & playing;
    assign done     = done_q;
    assign beat_idx = beat_idx_q;
    assign note_cur = note_q;

endmodule

// File: tb/tb_auto_music_player.sv
// Directed bench for auto_music_player: sequencing, pause, loop, reset and tone period.
module tb_auto_music_player;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic [0:0] song_sel = 1'b0;
    logic       buzzer, playing, paused, done;
    logic [2:0] beat_idx;
    logic [4:0] note_cur;

    logic       t_start = 1'b0, t_zero = 1'b0;
    logic [0:0] t_song = 1'b0;
    logic       t_buzzer, t_playing, t_paused, t_done;
    logic [2:0] t_beat_idx;
    logic [4:0] t_note_cur;

    int n_checks = 0;
    int n_pass   = 0;
    int song1_notes [8] = '{1, 3, 5, 8, 0, 15, 21, 25};

    always #5 clk = ~clk;

    auto_music_player #(
        .CLK_HZ(100000), .BEAT_CYCLES(4), .SONG_LEN(8), .NUM_SONGS(2), .NOTE_W(5)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .song_sel(song_sel), .buzzer(buzzer), .playing(playing),
        .paused(paused), .done(done), .beat_idx(beat_idx), .note_cur(note_cur)
    );

    // Long beats so a single note's tone period is observable.
    auto_music_player #(
        .CLK_HZ(100000), .BEAT_CYCLES(1000), .SONG_LEN(8), .NUM_SONGS(2), .NOTE_W(5)
    ) u_tone (
        .clk(clk), .rst(rst), .start(t_start), .stop(t_zero), .pause(t_zero),
        .loop_en(t_zero), .song_sel(t_song), .buzzer(t_buzzer), .playing(t_playing),
        .paused(t_paused), .done(t_done), .beat_idx(t_beat_idx), .note_cur(t_note_cur)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int dcount;
    int nt;
    int edges [3];
    logic prev;

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        tick();
        $display("[tb] reset state");
        check("rst_playing", int'(playing), 0);
        check("rst_paused", int'(paused), 0);
        check("rst_done", int'(done), 0);
        check("rst_beat_idx", int'(beat_idx), 0);
        check("rst_note_cur", int'(note_cur), 0);
        check("rst_buzzer", int'(buzzer), 0);

        $display("[tb] tone period, note 8");
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        prev = t_buzzer;
        nt = 0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (t_buzzer != prev) begin
                if (nt < 3) edges[nt] = k;
                nt++;
                prev = t_buzzer;
            end
        end
        check("tone_note", int'(t_note_cur), 8);
        check("tone_edges", nt, 3);
        check("tone_first", edges[0], 96);
        check("tone_half1", edges[1] - edges[0], 95);
        check("tone_half2", edges[2] - edges[1], 95);

        $display("[tb] song 1, no loop");
        song_sel = 1'b1;
        loop_en  = 1'b0;
        start    = 1'b1;
        tick();
        start  = 1'b0;
        dcount = 0;
        check("a_playing", int'(playing), 1);
        for (int k = 0; k <= 36; k++) begin
            if (k > 0) tick();
            if (done) begin
                dcount++;
                check("a_done_cycle", k, 32);
            end
            if (k < 32) check("a_beat_idx", int'(beat_idx), k / 4);
            if (k < 32 && k % 4 == 2) check("a_note_cur", int'(note_cur), song1_notes[k / 4]);
            if (k == 18) check("a_rest_buzzer", int'(buzzer), 0);
            if (k == 32) check("a_playing_end", int'(playing), 0);
        end
        check("a_done_count", dcount, 1);
        check("a_buzzer_done", int'(buzzer), 0);
        check("a_paused_done", int'(paused), 0);

        $display("[tb] reset during beat 3");
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (13) tick();
        check("r_beat_pre", int'(beat_idx), 3);
        check("r_note_pre", int'(note_cur), 8);
        #2 rst = 1'b1;
        #1;
        check("r_playing", int'(playing), 0);
        check("r_beat_idx", int'(beat_idx), 0);
        check("r_note_cur", int'(note_cur), 0);
        check("r_buzzer", int'(buzzer), 0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("r_stay_idle", int'(playing), 0);
        check("r_stay_beat", int'(beat_idx), 0);

        $display("[tb] pause at beat 2, cnt 1");
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("p_beat_before", int'(beat_idx), 2);
        pause = 1'b1;
        for (int k = 10; k <= 19; k++) begin
            tick();
            if (k == 10 || k == 19) begin
                check("p_paused", int'(paused), 1);
                check("p_playing", int'(playing), 0);
                check("p_buzzer", int'(buzzer), 0);
                check("p_beat_idx", int'(beat_idx), 2);
            end
        end
        pause = 1'b0;
        tick();
        check("p_resume_playing", int'(playing), 1);
        repeat (2) tick();
        check("p_beat_hold", int'(beat_idx), 2);
        tick();
        check("p_beat_adv", int'(beat_idx), 3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("p_stop_playing", int'(playing), 0);
        check("p_stop_beat", int'(beat_idx), 0);

        $display("[tb] start and stop together in idle");
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("s_idle", int'(playing), 0);
        tick();
        check("s_idle2", int'(playing), 0);

        $display("[tb] loop mode");
        loop_en = 1'b1;
        start   = 1'b1;
        tick();
        start  = 1'b0;
        dcount = 0;
        for (int k = 0; k <= 70; k++) begin
            if (k > 0) tick();
            if (done) begin
                dcount++;
                check("l_done_at", int'(k == 32 || k == 64), 1);
            end
            if (k == 32) begin
                check("l_wrap_beat", int'(beat_idx), 0);
                check("l_wrap_playing", int'(playing), 1);
            end
            if (k == 31) check("l_last_beat", int'(beat_idx), 7);
            if (k == 44) check("l_ignore_start_beat", int'(beat_idx), 3);
            if (k == 46) check("l_ignore_start_note", int'(note_cur), song1_notes[3]);
            if (k == 39) begin
                start    = 1'b1;
                song_sel = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        check("l_done_count", dcount, 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("l_stop_playing", int'(playing), 0);
        check("l_stop_buzzer", int'(buzzer), 0);
        check("l_stop_done", int'(done), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
